// File: rtl/hazard_scheduler.sv
// rtl/hazard_scheduler.sv - forwarding selects, load/branch/mult-div stalls, flush and stall accounting
// for a five-stage MIPS-style pipeline; all decisions are combinational apart from the mult/div FSM.
module hazard_scheduler #(
    parameter int MD_LATENCY = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  IF_ID_Rs,
    input  logic [4:0]  IF_ID_Rt,
    input  logic        ID_Branch,
    input  logic        ID_UsesRt,
    input  logic        ID_MdStart,
    input  logic        ID_MdRead,
    input  logic [4:0]  ID_EX_Rs,
    input  logic [4:0]  ID_EX_Rt,
    input  logic [4:0]  ID_EX_Rd,
    input  logic        ID_EX_RegWrite,
    input  logic        ID_EX_MemRead,
    input  logic [4:0]  EX_MEM_Rd,
    input  logic        EX_MEM_RegWrite,
    input  logic        EX_MEM_MemRead,
    input  logic [4:0]  MEM_WB_Rd,
    input  logic        MEM_WB_RegWrite,
    input  logic        BranchTaken,
    output logic [1:0]  ForwardA,
    output logic [1:0]  ForwardB,
    output logic [1:0]  ForwardC,
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic        ID_EX_Bubble,
    output logic        IF_Flush,
    output logic        MdBusy,
    output logic [31:0] StallCount
);

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MD_BUSY = 1'b1;

    localparam logic [7:0] MD_LOAD = 8'(MD_LATENCY - 1);

    logic [0:0]  state_q, state_d;
    logic [7:0]  md_cnt_q, md_cnt_d;
    logic [31:0] stall_count_q, stall_count_d;

    logic [1:0] fwd_a, fwd_b, fwd_c;
    logic       ex_mem_alu;
    logic       br_fwd_rs, br_fwd_rt;
    logic       br_ex_dep, br_load_dep;
    logic       load_use_stall, br_stall, md_stall, stall;

    // $0 is hardwired, so it never counts as a producer/consumer match.
    function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    always_comb begin
        fwd_a = 2'b00;
        if (EX_MEM_RegWrite && reg_hit(EX_MEM_Rd, ID_EX_Rs)) begin
            fwd_a = 2'b10;
        end else if (MEM_WB_RegWrite && reg_hit(MEM_WB_Rd, ID_EX_Rs)) begin
            fwd_a = 2'b01;
        end

        fwd_b = 2'b00;
        if (EX_MEM_RegWrite && reg_hit(EX_MEM_Rd, ID_EX_Rt)) begin
            fwd_b = 2'b10;
        end else if (MEM_WB_RegWrite && reg_hit(MEM_WB_Rd, ID_EX_Rt)) begin
            fwd_b = 2'b01;
        end
    end

    always_comb begin
        ex_mem_alu  = EX_MEM_RegWrite && !EX_MEM_MemRead;
        br_fwd_rs   = ex_mem_alu && reg_hit(EX_MEM_Rd, IF_ID_Rs);
        br_fwd_rt   = ex_mem_alu && reg_hit(EX_MEM_Rd, IF_ID_Rt);
        br_ex_dep   = ID_EX_RegWrite &&
                      (reg_hit(ID_EX_Rd, IF_ID_Rs) || reg_hit(ID_EX_Rd, IF_ID_Rt));
        br_load_dep = EX_MEM_MemRead &&
                      (reg_hit(EX_MEM_Rd, IF_ID_Rs) || reg_hit(EX_MEM_Rd, IF_ID_Rt));

        load_use_stall = ID_EX_MemRead &&
                         (reg_hit(ID_EX_Rd, IF_ID_Rs) ||
                          (ID_UsesRt && reg_hit(ID_EX_Rd, IF_ID_Rt)));
        // The compare path has only one forwarding mux input, so a double dependency waits.
        br_stall = ID_Branch && (br_ex_dep || br_load_dep || (br_fwd_rs && br_fwd_rt));
        md_stall = (state_q == ST_MD_BUSY) && (ID_MdRead || ID_MdStart);
        stall    = load_use_stall || br_stall || md_stall;

        fwd_c = 2'b00;
        if (ID_Branch && !(br_fwd_rs && br_fwd_rt)) begin
            if (br_fwd_rs) begin
                fwd_c = 2'b01;
            end else if (br_fwd_rt) begin
                fwd_c = 2'b10;
            end
        end
    end

    always_comb begin
        ForwardA     = 2'b00;
        ForwardB     = 2'b00;
        ForwardC     = 2'b00;
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
        IF_Flush     = 1'b0;
        MdBusy       = 1'b0;
        if (rst_n) begin
            ForwardA     = fwd_a;
            ForwardB     = fwd_b;
            ForwardC     = fwd_c;
            PC_Write     = !stall;
            IF_ID_Write  = !stall;
            ID_EX_Bubble = stall;
            IF_Flush     = ID_Branch && BranchTaken && !stall;
            MdBusy       = (state_q == ST_MD_BUSY);
        end
        StallCount = stall_count_q;
    end

    always_comb begin
        state_d       = state_q;
        md_cnt_d      = md_cnt_q;
        stall_count_d = stall_count_q;

        case (state_q)
            ST_RUN: begin
                if (ID_MdStart && !stall) begin
                    state_d  = ST_MD_BUSY;
                    md_cnt_d = MD_LOAD;
                end
            end
            ST_MD_BUSY: begin
                if (md_cnt_q == 8'd0) begin
                    state_d = ST_RUN;
                end else begin
                    md_cnt_d = md_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d  = ST_RUN;
                md_cnt_d = 8'd0;
            end
        endcase

        if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            md_cnt_q      <= 8'd0;
            stall_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            md_cnt_q      <= md_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule
